// File: rtl/dm_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_rmw_ctrl
// Purpose  : Data-memory access sequencer between the MEM stage and a
//            word-only data memory. Loads and full-word stores pass straight
//            through in the same cycle. Partial (byte/halfword-lane) stores
//            are expanded into a READ/WRITE read-modify-write sequence while
//            the pipeline is stalled.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW        byte address width (dm decodes the word from addr[13:2])
//   CNT_W     width of the saturating completed-RMW counter
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wpc                   PC of the instruction in MEM
//   req_we/be/addr/wdat   MEM stage request (store enable, lanes, addr, data)
//   rdat                  load data back to MEM (always equals dm_rdat)
//   stall                 freeze IF..MEM this cycle
//   dm_addr/wdat/write/wpc  request to the data memory
//   dm_rdat               asynchronous read data from the data memory
//   rmw_count             number of completed read-modify-write stores
// Optional build macro
//   DM_RMW_TRACE_EN       prints a trace line for every dm write
// ============================================================================
module dm_rmw_ctrl #(
    parameter int AW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wpc,
    input  logic             req_we,
    input  logic [3:0]       req_be,
    input  logic [AW-1:0]    req_addr,
    input  logic [31:0]      req_wdat,
    output logic [31:0]      rdat,
    output logic             stall,
    output logic [AW-1:0]    dm_addr,
    output logic [31:0]      dm_wdat,
    output logic             dm_write,
    output logic [31:0]      dm_wpc,
    input  logic [31:0]      dm_rdat,
    output logic [CNT_W-1:0] rmw_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    hold_addr_q;
    logic [3:0]       hold_be_q;
    logic [31:0]      hold_wdat_q;
    logic [31:0]      hold_pc_q;
    logic [31:0]      hold_rdat_q;
    logic [CNT_W-1:0] rmw_count_q;
    // High for the first cycle after reset is released; stores are
    // suppressed in that cycle so the pipeline can settle.
    logic             post_rst_q;

    logic             w_full;
    logic             w_partial;
    logic             w_block;
    logic [31:0]      w_merge;

    assign w_full    = req_we && (req_be == 4'hF);
    assign w_partial = req_we && (req_be != 4'h0) && (req_be != 4'hF);
    assign w_block   = rst || post_rst_q;

    // Merge works purely from registered data, so dm_rdat never reaches
    // dm_wdat combinationally. Any lane mask (contiguous or not) works.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_merge[8*i +: 8] = hold_be_q[i] ? hold_wdat_q[8*i +: 8]
                                                : hold_rdat_q[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_addr_q <= '0;
            hold_be_q   <= '0;
            hold_wdat_q <= '0;
            hold_pc_q   <= '0;
            hold_rdat_q <= '0;
            rmw_count_q <= '0;
            post_rst_q  <= 1'b1;
        end else begin
            post_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_partial && !post_rst_q) begin
                        hold_addr_q <= req_addr;
                        hold_be_q   <= req_be;
                        hold_wdat_q <= req_wdat;
                        hold_pc_q   <= wpc;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    hold_rdat_q <= dm_rdat;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    if (rmw_count_q != {CNT_W{1'b1}}) begin
                        rmw_count_q <= rmw_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and the live request so that loads and
    // full stores see zero added latency.
    always_comb begin
        stall    = 1'b0;
        dm_write = 1'b0;
        dm_addr  = req_addr;
        dm_wdat  = req_wdat;
        dm_wpc   = wpc;
        case (state_q)
            IDLE: begin
                if (!w_block) begin
                    dm_write = w_full;
                    stall    = w_partial;
                end
            end
            READ: begin
                dm_addr = hold_addr_q;
                dm_wdat = hold_wdat_q;
                dm_wpc  = hold_pc_q;
                stall   = !rst;
            end
            WRITE: begin
                // Request inputs are ignored here: they still belong to the
                // store being completed.
                dm_addr  = hold_addr_q;
                dm_wdat  = w_merge;
                dm_wpc   = hold_pc_q;
                dm_write = !rst;
            end
            default: ;
        endcase
    end

    assign rdat      = dm_rdat;
    assign rmw_count = rmw_count_q;

`ifdef DM_RMW_TRACE_EN
    always @(posedge clk) begin
        if (!rst && dm_write) begin
            $display("%d@%h: *%h <= %h", $time, dm_wpc, dm_addr, dm_wdat);
            if (state_q == WRITE) begin
                $display("    rmw be=%b old=%h", hold_be_q, hold_rdat_q);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_rmw_ctrl
// Purpose  : Directed self-checking bench for dm_rmw_ctrl with a word memory
//            model behind the dm port. The counter is built 2 bits wide so
//            that saturation at 3 is reached by the directed sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_rmw_ctrl;

    localparam int AW    = 32;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [31:0]      wpc;
    logic             req_we;
    logic [3:0]       req_be;
    logic [AW-1:0]    req_addr;
    logic [31:0]      req_wdat;
    logic [31:0]      rdat;
    logic             stall;
    logic [AW-1:0]    dm_addr;
    logic [31:0]      dm_wdat;
    logic             dm_write;
    logic [31:0]      dm_wpc;
    logic [31:0]      dm_rdat;
    logic [CNT_W-1:0] rmw_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:4095];

    dm_rmw_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wpc       (wpc),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdat  (req_wdat),
        .rdat      (rdat),
        .stall     (stall),
        .dm_addr   (dm_addr),
        .dm_wdat   (dm_wdat),
        .dm_write  (dm_write),
        .dm_wpc    (dm_wpc),
        .dm_rdat   (dm_rdat),
        .rmw_count (rmw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: asynchronous read, synchronous write.
    assign dm_rdat = mem[dm_addr[13:2]];
    always @(posedge clk) begin
        if (dm_write) mem[dm_addr[13:2]] <= dm_wdat;
    end

    // Tasks run from posedge+1; outputs are sampled 3 time units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pc);
        req_we   = we;
        req_be   = be;
        req_addr = addr;
        req_wdat = wd;
        wpc      = pc;
    endtask

    // Runs one partial store through IDLE/READ/WRITE and records what the DUT
    // showed each cycle. In the WRITE cycle the request is corrupted to prove
    // it is ignored.
    task automatic rmw_cycle(input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input logic [31:0] pc,
                             output logic [2:0] st, output logic [2:0] wr,
                             output logic [31:0] wdat_obs,
                             output logic [31:0] wpc_obs);
        drive(1'b1, be, addr, wd, pc);
        wdat_obs = '0;
        wpc_obs  = '0;
        for (int c = 0; c < 3; c++) begin
            #3;
            st[c] = stall;
            wr[c] = dm_write;
            if (c == 2) begin
                wdat_obs = dm_wdat;
                wpc_obs  = dm_wpc;
            end
            next_cycle();
            if (c == 1) drive(1'b1, 4'hF, addr + 32'h100, ~wd, pc + 32'h4);
        end
        drive(1'b0, 4'h0, addr, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'hF, 32'h10, 32'h99999999, 32'h0);
        next_cycle();
        #3;
        checks++;
        if (dm_write !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: dm_write=%b stall=%b required 0 0", dm_write, stall);
        end
        checks++;
        if (rmw_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", rmw_count);
        end
        next_cycle();
        rst = 1'b0;
        #3;
        checks++;
        if (dm_write !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_outputs: dm_write=%b stall=%b required 0 0", dm_write, stall);
        end
        next_cycle();
        drive(1'b0, 4'h0, 32'h10, 32'h0, 32'h0);
        #3;
        checks++;
        if (rdat !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_write: rdat=%h required 00000000", rdat);
        end
        next_cycle();
    endtask

    task automatic test_full_store();
        drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h100);
        #3;
        checks++;
        if (dm_write !== 1'b1 || stall !== 1'b0 || dm_wdat !== 32'hDEADBEEF ||
            dm_addr !== 32'h10 || dm_wpc !== 32'h100) begin
            errors++;
            $display("FAIL full_store: write=%b stall=%b wdat=%h addr=%h wpc=%h required 1 0 deadbeef 10 100",
                     dm_write, stall, dm_wdat, dm_addr, dm_wpc);
        end
        next_cycle();
        drive(1'b0, 4'h0, 32'h10, 32'h0, 32'h0);
        #3;
        checks++;
        if (rdat !== 32'hDEADBEEF || stall !== 1'b0) begin
            errors++;
            $display("FAIL full_load: rdat=%h stall=%b required deadbeef 0", rdat, stall);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 4'hF, 32'h40, 32'h12345678, 32'h200);
        next_cycle();
        drive(1'b1, 4'h1, 32'h40, 32'h000000FF, 32'h204);
        #3;
        checks++;
        if (stall !== 1'b1 || dm_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_start: stall=%b write=%b required 1 0", stall, dm_write);
        end
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h40, 32'h0, 32'h0);
        #3;
        checks++;
        if (dm_write !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_read: write=%b stall=%b required 0 0", dm_write, stall);
        end
        next_cycle();
        rst = 1'b0;
        #3;
        checks++;
        if (dm_write !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_after: write=%b stall=%b required 0 0", dm_write, stall);
        end
        next_cycle();
        #3;
        checks++;
        if (rdat !== 32'h12345678 || stall !== 1'b0 || dm_write !== 1'b0 || rmw_count !== 2'd0) begin
            errors++;
            $display("FAIL abort_result: rdat=%h stall=%b write=%b count=%0d required 12345678 0 0 0",
                     rdat, stall, dm_write, rmw_count);
        end
        next_cycle();
    endtask

    task automatic test_partial();
        logic [2:0]  st, wr;
        logic [31:0] wd, pc;
        rmw_cycle(32'h10, 4'b0001, 32'h000000AA, 32'h104, st, wr, wd, pc);
        checks++;
        if (st !== 3'b011) begin
            errors++;
            $display("FAIL partial_stall: cycles(2..0)=%b required 011", st);
        end
        checks++;
        if (wr !== 3'b100 || wd !== 32'hDEADBEAA || pc !== 32'h104) begin
            errors++;
            $display("FAIL partial_write: wr=%b wdat=%h wpc=%h required 100 deadbeaa 104", wr, wd, pc);
        end
        drive(1'b0, 4'h0, 32'h10, 32'h0, 32'h0);
        #3;
        checks++;
        if (rdat !== 32'hDEADBEAA || rmw_count !== 2'd1) begin
            errors++;
            $display("FAIL partial_result: rdat=%h count=%0d required deadbeaa 1", rdat, rmw_count);
        end
        next_cycle();
    endtask

    task automatic test_masks();
        logic [2:0]  st, wr;
        logic [31:0] wd, pc;
        drive(1'b1, 4'hF, 32'h20, 32'h11223344, 32'h300);
        next_cycle();
        rmw_cycle(32'h20, 4'b1100, 32'hABCD0000, 32'h304, st, wr, wd, pc);
        checks++;
        if (wd !== 32'hABCD3344 || wr !== 3'b100) begin
            errors++;
            $display("FAIL halfword_merge: wdat=%h wr=%b required abcd3344 100", wd, wr);
        end
        rmw_cycle(32'h20, 4'b1001, 32'h55000066, 32'h308, st, wr, wd, pc);
        checks++;
        if (wd !== 32'h55CD3366 || wr !== 3'b100) begin
            errors++;
            $display("FAIL noncontig_merge: wdat=%h wr=%b required 55cd3366 100", wd, wr);
        end
        #3;
        checks++;
        if (rdat !== 32'h55CD3366 || rmw_count !== 2'd3) begin
            errors++;
            $display("FAIL masks_result: rdat=%h count=%0d required 55cd3366 3", rdat, rmw_count);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  st1, wr1, st2, wr2;
        logic [31:0] wd1, wd2, pc1, pc2;
        int          nstall;
        drive(1'b1, 4'hF, 32'h30, 32'hA0B0C0D0, 32'h400);
        next_cycle();
        rmw_cycle(32'h30, 4'b0010, 32'h00001100, 32'h404, st1, wr1, wd1, pc1);
        rmw_cycle(32'h30, 4'b0100, 32'h00220000, 32'h408, st2, wr2, wd2, pc2);
        #3;
        nstall = 0;
        for (int i = 0; i < 3; i++) nstall += int'(st1[i]) + int'(st2[i]);
        nstall += int'(stall);
        checks++;
        if (nstall != 4) begin
            errors++;
            $display("FAIL b2b_stalls: got %0d required 4", nstall);
        end
        checks++;
        if (wd1 !== 32'hA0B011D0 || wd2 !== 32'hA02211D0 || pc2 !== 32'h408) begin
            errors++;
            $display("FAIL b2b_merge: first=%h second=%h wpc=%h required a0b011d0 a02211d0 408", wd1, wd2, pc2);
        end
        checks++;
        if (rdat !== 32'hA02211D0 || rmw_count !== 2'd3) begin
            errors++;
            $display("FAIL b2b_load: rdat=%h count=%0d required a02211d0 3 (saturated)", rdat, rmw_count);
        end
        next_cycle();
    endtask

    task automatic test_null_load();
        drive(1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 32'h500);
        #3;
        checks++;
        if (dm_write !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL null_store: write=%b stall=%b required 0 0", dm_write, stall);
        end
        next_cycle();
        drive(1'b0, 4'h0, 32'h30, 32'h0, 32'h0);
        #3;
        checks++;
        if (rdat !== 32'hA02211D0 || stall !== 1'b0 || dm_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_load: rdat=%h stall=%b write=%b required a02211d0 0 0", rdat, stall, dm_write);
        end
        next_cycle();
        drive(1'b0, 4'h0, 32'h10, 32'h0, 32'h0);
        #3;
        checks++;
        if (rdat !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL idle_load2: rdat=%h required deadbeaa", rdat);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        #1;
        test_reset();
        test_full_store();
        test_reset_mid_op();
        test_partial();
        test_masks();
        test_back_to_back();
        test_null_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
